input_debounce_2ch: RTL and testbench

//  Two-channel input conditioner sitting directly upstream of the a/b-driven control FSM.

---
 rtl/input_debounce_2ch_pkg.sv | 18 +
 rtl/input_debounce_2ch_chan.sv | 90 +++++++++
 rtl/input_debounce_2ch.sv | 50 +++++
 tb/tb_input_debounce_2ch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_2ch_pkg.sv
// ---------------------------------------------------------------------------
// input_debounce_2ch_pkg
//   Shared definitions for the two-channel switch debouncer.
//   - db_state_e : per-channel debounce FSM state encoding
//   - NUM_CH     : number of independent channels in the top
// ---------------------------------------------------------------------------
package input_debounce_2ch_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,   // settled low
        WAIT1 = 2'b01,   // low, candidate high being timed
        ONE   = 2'b10,   // settled high
        WAIT0 = 2'b11    // high, candidate low being timed
    } db_state_e;

    localparam int NUM_CH = 2;

endpackage

// File: rtl/input_debounce_2ch_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan
//   One debounce lane: synchroniser chain, 4-state FSM and N-bit down-counter.
//   Ports:
//     clk      in  system clock (rising edge)
//     reset_n  in  asynchronous active-low reset
//     sw       in  raw asynchronous, bouncing input
//     db_level out debounced level (Moore, from state only)
//     db_tick  out one-cycle pulse in the cycle before db_level rises
// ---------------------------------------------------------------------------
module debounce_chan
    import input_debounce_2ch_pkg::*;
#(
    parameter int N           = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [N-1:0]           cnt_q;
    logic                   cnt_load, cnt_dec;

    // Synchroniser: sw enters at bit 0, s is taken from the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sw};
    end

    assign s = sync_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ZERO;
        else          state_q <= state_d;
    end

    // Reloaded on every WAIT entry and only decremented while non-zero,
    // so it can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt_q <= '0;
        else if (cnt_load) cnt_q <= '1;
        else if (cnt_dec)  cnt_q <= cnt_q - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        db_tick  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d  = WAIT1;
                    cnt_load = 1'b1;
                end
            end
            WAIT1: begin
                if (!s)                state_d = ZERO;
                else if (cnt_q != '0)  cnt_dec = 1'b1;
                else begin
                    // Window expired with s still high: rise next edge.
                    state_d = ONE;
                    db_tick = 1'b1;
                end
            end
            ONE: begin
                if (!s) begin
                    state_d  = WAIT0;
                    cnt_load = 1'b1;
                end
            end
            WAIT0: begin
                if (s)                 state_d = ONE;
                else if (cnt_q != '0)  cnt_dec = 1'b1;
                else                   state_d = ZERO;
            end
            default: state_d = ZERO;
        endcase
    end

    // Level is high in ONE and WAIT0 (the high-side states).
    assign db_level = (state_q == ONE) || (state_q == WAIT0);

endmodule

// File: rtl/input_debounce_2ch.sv
// ---------------------------------------------------------------------------
// input_debounce_2ch
//   Two independent debounce lanes for raw switch inputs A and B.
//   Ports:
//     clk      in  system clock (rising edge)
//     reset_n  in  asynchronous active-low reset
//     sw_a     in  raw input A
//     sw_b     in  raw input B
//     a, b     out debounced levels
//     a_tick   out one-cycle pulse on debounced 0->1 of A
//     b_tick   out one-cycle pulse on debounced 0->1 of B
// ---------------------------------------------------------------------------
module input_debounce_2ch
    import input_debounce_2ch_pkg::*;
#(
    parameter int N           = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_a,
    input  logic sw_b,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);

    // Lane 0 = A, lane 1 = B.
    logic [NUM_CH-1:0] sw_v, lvl_v, tick_v;

    assign sw_v = {sw_b, sw_a};

    debounce_chan #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chan [NUM_CH-1:0] (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw_v),
        .db_level (lvl_v),
        .db_tick  (tick_v)
    );

    assign a      = lvl_v[0];
    assign b      = lvl_v[1];
    assign a_tick = tick_v[0];
    assign b_tick = tick_v[1];

endmodule

// File: tb/tb_input_debounce_2ch.sv
module tb_input_debounce_2ch;
    localparam int N  = 2;
    localparam int SS = 2;
    localparam int W  = 1 << N;

    logic clk = 1'b0;
    logic reset_n, sw_a, sw_b;
    logic a, b, a_tick, b_tick;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    typedef struct packed {
        logic a;
        logic b;
        logic ta;
        logic tb;
    } exp_t;

    exp_t sb[$];

    input_debounce_2ch #(.N(N), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw_a    (sw_a),
        .sw_b    (sw_b),
        .a       (a),
        .b       (b),
        .a_tick  (a_tick),
        .b_tick  (b_tick)
    );

    always #5 clk = ~clk;

    // Reference: output follows s once s has disagreed with it for W+1
    // consecutive sampling edges; s is the raw input delayed by SS edges.
    logic m_dly [2][SS];
    logic m_out [2];
    int   m_run [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_out[c] = 1'b0;
            m_run[c] = 0;
            for (int k = 0; k < SS; k++) m_dly[c][k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic ra, input logic rb);
        logic raw [2];
        logic s;
        raw[0] = ra;
        raw[1] = rb;
        for (int c = 0; c < 2; c++) begin
            s = m_dly[c][SS-1];
            if (s != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == W + 1) begin
                    m_out[c] = s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            for (int k = SS - 1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
            m_dly[c][0] = raw[c];
        end
    endtask

    function automatic logic model_tick(input int c);
        return (m_out[c] == 1'b0) && (m_dly[c][SS-1] == 1'b1) && (m_run[c] == W);
    endfunction

    // One clock cycle: apply inputs just after an edge, queue expectations for
    // this cycle, then advance the model across the next edge.
    task automatic cyc(input logic ra, input logic rb, input logic rn);
        exp_t e;
        sw_a    = ra;
        sw_b    = rb;
        reset_n = rn;
        if (!rn) model_reset();
        e.a  = m_out[0];
        e.b  = m_out[1];
        e.ta = model_tick(0);
        e.tb = model_tick(1);
        sb.push_back(e);
        @(posedge clk);
        if (rn) model_edge(ra, rb);
        #1;
    endtask

    task automatic check(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0b want=%0b", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty t=%0t got=0 want=1", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("a",      a,      e.a);
                check("b",      b,      e.b);
                check("a_tick", a_tick, e.ta);
                check("b_tick", b_tick, e.tb);
            end
        end
    end

    initial begin
        logic ra, rb;
        int   pflip;
        reset_n = 1'b0;
        sw_a    = 1'b1;
        sw_b    = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        started = 1'b1;

        // 1: reset held with inputs high, then release with inputs held high
        repeat (5) cyc(1, 1, 0);
        repeat (10) cyc(1, 1, 1);

        // 2: clean rise then clean fall on A
        repeat (10) cyc(0, 0, 1);
        repeat (10) cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);

        // 3: A bounces then settles high
        begin
            logic [9:0] pat;
            pat = 10'b1111110111;  // bit 0 first: 1,1,1,0,1,1,1,1,1,1
            for (int i = 0; i < 10; i++) cyc(pat[i], 0, 1);
            repeat (6) cyc(1, 0, 1);
            repeat (10) cyc(0, 0, 1);
        end

        // 4: short B pulse, then a full-length attempt
        repeat (3) cyc(0, 1, 1);
        repeat (6) cyc(0, 0, 1);
        repeat (10) cyc(0, 1, 1);
        repeat (10) cyc(0, 0, 1);

        // 5: both rise together, B glitches low once on its third cycle
        for (int i = 0; i < 14; i++) cyc(1, (i == 2) ? 1'b0 : 1'b1, 1);
        repeat (10) cyc(0, 0, 1);

        // 6: reset pulse while A is mid-window
        repeat (3) cyc(1, 0, 1);
        cyc(1, 0, 0);
        repeat (10) cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);

        // Random bouncing with varying flip density and occasional resets
        ra = 1'b0;
        rb = 1'b0;
        for (int seg = 0; seg < 40; seg++) begin
            pflip = $urandom_range(1, 16);
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 31) < pflip) ra = ~ra;
                if ($urandom_range(0, 31) < pflip) rb = ~rb;
                cyc(ra, rb, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
            end
            repeat ($urandom_range(0, 8)) cyc(ra, rb, 1);
        end

        started = 1'b0;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
